// File: rtl/axi4_slave_pkg.sv
// Shared encodings and helpers for the AXI4 burst slave.
// Burst/response codes, FSM states and the per-beat error rule.
package axi4_slave_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    // A beat is in error if it falls outside the array or the command is unsupported.
    function automatic logic beat_err(
        input logic [31:0] addr,
        input logic [1:0]  burst,
        input logic [2:0]  size,
        input int unsigned words
    );
        return ({2'b00, addr[31:2]} >= words) ||
               ((burst != BURST_FIXED) && (burst != BURST_INCR)) ||
               (size != SIZE_WORD);
    endfunction

endpackage

// File: rtl/axi4_burst_slave_if.sv
// AXI4 full write/read channel bundle between a burst master and slave.
interface axi4_burst_slave_if #(
    parameter int ID_W = 4
);
    import axi4_slave_pkg::*;

    logic [31:0]     S_AXI_AWADDR;
    logic [7:0]      S_AXI_AWLEN;
    logic [2:0]      S_AXI_AWSIZE;
    logic [1:0]      S_AXI_AWBURST;
    logic [ID_W-1:0] S_AXI_AWID;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [2:0]      S_AXI_AWPROT;
    logic [3:0]      S_AXI_AWCACHE;
    logic            S_AXI_AWLOCK;
    logic [3:0]      S_AXI_AWQOS;
    logic [3:0]      S_AXI_AWREGION;

    logic [31:0]     S_AXI_WDATA;
    logic [3:0]      S_AXI_WSTRB;
    logic            S_AXI_WLAST;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;

    logic [1:0]      S_AXI_BRESP;
    logic [ID_W-1:0] S_AXI_BID;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;

    logic [31:0]     S_AXI_ARADDR;
    logic [7:0]      S_AXI_ARLEN;
    logic [2:0]      S_AXI_ARSIZE;
    logic [1:0]      S_AXI_ARBURST;
    logic [ID_W-1:0] S_AXI_ARID;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [2:0]      S_AXI_ARPROT;
    logic [3:0]      S_AXI_ARCACHE;
    logic            S_AXI_ARLOCK;
    logic [3:0]      S_AXI_ARQOS;
    logic [3:0]      S_AXI_ARREGION;

    logic [31:0]     S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic [ID_W-1:0] S_AXI_RID;
    logic            S_AXI_RLAST;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
        input  S_AXI_AWID, S_AXI_AWVALID,
        input  S_AXI_AWPROT, S_AXI_AWCACHE, S_AXI_AWLOCK,
        input  S_AXI_AWQOS, S_AXI_AWREGION,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BID, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
        input  S_AXI_ARID, S_AXI_ARVALID,
        input  S_AXI_ARPROT, S_AXI_ARCACHE, S_AXI_ARLOCK,
        input  S_AXI_ARQOS, S_AXI_ARREGION,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RID, S_AXI_RLAST,
        output S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
        output S_AXI_AWID, S_AXI_AWVALID,
        output S_AXI_AWPROT, S_AXI_AWCACHE, S_AXI_AWLOCK,
        output S_AXI_AWQOS, S_AXI_AWREGION,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BID, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
        output S_AXI_ARID, S_AXI_ARVALID,
        output S_AXI_ARPROT, S_AXI_ARCACHE, S_AXI_ARLOCK,
        output S_AXI_ARQOS, S_AXI_ARREGION,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RID, S_AXI_RLAST,
        input  S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/axi4_slave_mem.sv
// Word array with one byte-enabled write port, one combinational
// read port and an asynchronous clear.
module axi4_slave_mem
    import axi4_slave_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_widx,
    input  logic [3:0]    i_wstrb,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_ridx,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [MEM_WORDS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Combinational read sees the pre-write contents in a colliding cycle.
    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/axi4_burst_slave.sv
// Memory-backed AXI4 slave: one outstanding write and one outstanding
// read burst, INCR/FIXED at one beat per cycle.
module axi4_burst_slave
    import axi4_slave_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int ID_W      = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    axi4_burst_slave_if.slave s_axi
);

    localparam int AW = $clog2(MEM_WORDS);

    wstate_e         r_wstate;
    logic            r_awready;
    logic            r_wready;
    logic            r_bvalid;
    logic [1:0]      r_bresp;
    logic [ID_W-1:0] r_bid;
    logic [31:0]     r_waddr;
    logic [7:0]      r_awlen;
    logic [7:0]      r_wcnt;
    logic [1:0]      r_awburst;
    logic [2:0]      r_awsize;
    logic            r_werr;

    rstate_e         r_rstate;
    logic            r_arready;
    logic            r_rvalid;
    logic            r_rlast;
    logic [1:0]      r_rresp;
    logic [ID_W-1:0] r_rid;
    logic [31:0]     r_raddr;
    logic [31:0]     r_rdata;
    logic [7:0]      r_arlen;
    logic [7:0]      r_rcnt;
    logic [1:0]      r_arburst;
    logic [2:0]      r_arsize;

    logic        w_awhs;
    logic        w_whs;
    logic        w_wfinal;
    logic        w_wbeat_err;
    logic        w_wlast_err;
    logic        w_we;
    logic        w_arhs;
    logic        w_rhs;
    logic        w_ridle;
    logic [31:0] w_rnext;
    logic [31:0] w_rd_addr;
    logic [1:0]  w_rd_burst;
    logic [2:0]  w_rd_size;
    logic        w_rd_err;
    logic [31:0] w_mem_rdata;
    logic [31:0] w_rd_word;
    logic [1:0]  w_rd_resp;
    logic        w_unused;

    assign w_awhs      = r_awready & s_axi.S_AXI_AWVALID;
    assign w_whs       = r_wready & s_axi.S_AXI_WVALID;
    assign w_wfinal    = (r_wcnt == r_awlen);
    assign w_wbeat_err = beat_err(r_waddr, r_awburst, r_awsize, MEM_WORDS);
    assign w_wlast_err = (s_axi.S_AXI_WLAST != w_wfinal);
    assign w_we        = w_whs & ~w_wbeat_err;

    assign w_arhs     = r_arready & s_axi.S_AXI_ARVALID;
    assign w_rhs      = r_rvalid & s_axi.S_AXI_RREADY;
    assign w_ridle    = (r_rstate == R_IDLE);
    assign w_rnext    = (r_arburst == BURST_INCR) ? r_raddr + 32'd4 : r_raddr;
    // Idle looks up beat 0 of the incoming command, otherwise the next beat.
    assign w_rd_addr  = w_ridle ? s_axi.S_AXI_ARADDR : w_rnext;
    assign w_rd_burst = w_ridle ? s_axi.S_AXI_ARBURST : r_arburst;
    assign w_rd_size  = w_ridle ? s_axi.S_AXI_ARSIZE : r_arsize;
    assign w_rd_err   = beat_err(w_rd_addr, w_rd_burst, w_rd_size, MEM_WORDS);
    assign w_rd_word  = w_rd_err ? 32'd0 : w_mem_rdata;
    assign w_rd_resp  = w_rd_err ? RESP_SLVERR : RESP_OKAY;

    axi4_slave_mem #(
        .MEM_WORDS(MEM_WORDS),
        .AW       (AW)
    ) u_mem (
        .i_clk  (ACLK),
        .i_rst  (ARESET),
        .i_we   (w_we),
        .i_widx (r_waddr[AW+1:2]),
        .i_wstrb(s_axi.S_AXI_WSTRB),
        .i_wdata(s_axi.S_AXI_WDATA),
        .i_ridx (w_rd_addr[AW+1:2]),
        .o_rdata(w_mem_rdata)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_bid     <= '0;
            r_waddr   <= '0;
            r_awlen   <= '0;
            r_wcnt    <= '0;
            r_awburst <= '0;
            r_awsize  <= '0;
            r_werr    <= 1'b0;
        end else begin
            unique case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (w_awhs) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_waddr   <= s_axi.S_AXI_AWADDR;
                        r_awlen   <= s_axi.S_AXI_AWLEN;
                        r_awburst <= s_axi.S_AXI_AWBURST;
                        r_awsize  <= s_axi.S_AXI_AWSIZE;
                        r_bid     <= s_axi.S_AXI_AWID;
                        r_wcnt    <= '0;
                        r_werr    <= 1'b0;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_whs) begin
                        r_wcnt <= r_wcnt + 8'd1;
                        if (r_awburst == BURST_INCR) begin
                            r_waddr <= r_waddr + 32'd4;
                        end
                        r_werr <= r_werr | w_wbeat_err | w_wlast_err;
                        // The burst ends on the AWLEN count whatever WLAST says.
                        if (w_wfinal) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr | w_wbeat_err | w_wlast_err)
                                      ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= RESP_OKAY;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rid     <= '0;
            r_raddr   <= '0;
            r_rdata   <= '0;
            r_arlen   <= '0;
            r_rcnt    <= '0;
            r_arburst <= '0;
            r_arsize  <= '0;
        end else begin
            unique case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_arhs) begin
                        r_arready <= 1'b0;
                        r_raddr   <= s_axi.S_AXI_ARADDR;
                        r_arlen   <= s_axi.S_AXI_ARLEN;
                        r_arburst <= s_axi.S_AXI_ARBURST;
                        r_arsize  <= s_axi.S_AXI_ARSIZE;
                        r_rid     <= s_axi.S_AXI_ARID;
                        r_rcnt    <= '0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_word;
                        r_rresp   <= w_rd_resp;
                        r_rlast   <= (s_axi.S_AXI_ARLEN == 8'd0);
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_rhs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_rdata   <= '0;
                            r_rresp   <= RESP_OKAY;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_raddr <= w_rnext;
                            r_rdata <= w_rd_word;
                            r_rresp <= w_rd_resp;
                            r_rlast <= ((r_rcnt + 8'd1) == r_arlen);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_BID     = r_bid;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign s_axi.S_AXI_RID     = r_rid;
    assign s_axi.S_AXI_RLAST   = r_rlast;

    assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_AWCACHE,
                        s_axi.S_AXI_AWLOCK, s_axi.S_AXI_AWQOS,
                        s_axi.S_AXI_AWREGION, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_ARCACHE, s_axi.S_AXI_ARLOCK,
                        s_axi.S_AXI_ARQOS, s_axi.S_AXI_ARREGION,
                        r_waddr[1:0], w_rd_addr[1:0]};

endmodule

// File: tb/tb_axi4_burst_slave.sv
// Directed bench for axi4_burst_slave: vector table of bursts plus
// hand sequences for reset and early W beats.
module tb_axi4_burst_slave;
    import axi4_slave_pkg::*;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    axi4_burst_slave_if #(.ID_W(4)) bus ();

    axi4_burst_slave #(
        .MEM_WORDS(64),
        .ID_W     (4)
    ) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .s_axi (bus)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [31:0] d[4];
        logic [3:0]  strb;
        bit          badlast;
        int          hold;
        logic [1:0]  bresp;
        logic [3:0]  emask;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input bit wr, input logic [31:0] a, input logic [7:0] len,
        input logic [1:0] bu, input logic [2:0] sz,
        input logic [31:0] d0, input logic [31:0] d1,
        input logic [31:0] d2, input logic [31:0] d3,
        input logic [3:0] strb, input bit bl, input int hold,
        input logic [1:0] br, input logic [3:0] em
    );
        vec_t v;
        v.wr = wr; v.addr = a; v.len = len; v.burst = bu; v.size = sz;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.strb = strb; v.badlast = bl; v.hold = hold;
        v.bresp = br; v.emask = em;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return bus.S_AXI_AWREADY;
            1:       return bus.S_AXI_WREADY;
            2:       return bus.S_AXI_BVALID;
            3:       return bus.S_AXI_ARREADY;
            default: return bus.S_AXI_RVALID;
        endcase
    endfunction

    task automatic wait_hi(input int w, input string nm);
        int t = 0;
        while (sig(w) !== 1'b1 && t < 64) begin
            @(negedge ACLK);
            t++;
        end
        if (sig(w) !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout waiting for handshake, got 0 expected 1", nm);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                    bus.S_AXI_BRESP, bus.S_AXI_BID, bus.S_AXI_ARREADY,
                    bus.S_AXI_RVALID, bus.S_AXI_RLAST, bus.S_AXI_RRESP,
                    bus.S_AXI_RID, bus.S_AXI_RDATA});
    endfunction

    task automatic run(input vec_t v, input logic [3:0] id, input string nm);
        logic [31:0] q;
        logic [1:0]  rs;
        if (v.wr) begin
            bus.S_AXI_AWADDR  = v.addr;
            bus.S_AXI_AWLEN   = v.len;
            bus.S_AXI_AWBURST = v.burst;
            bus.S_AXI_AWSIZE  = v.size;
            bus.S_AXI_AWID    = id;
            bus.S_AXI_AWVALID = 1'b1;
            wait_hi(0, {nm, "_aw"});
            @(posedge ACLK);
            @(negedge ACLK);
            bus.S_AXI_AWVALID = 1'b0;
            for (int i = 0; i <= int'(v.len); i++) begin
                bus.S_AXI_WDATA  = (i < 4) ? v.d[i] : 32'(i);
                bus.S_AXI_WSTRB  = v.strb;
                bus.S_AXI_WLAST  = (i == int'(v.len)) && !v.badlast;
                bus.S_AXI_WVALID = 1'b1;
                wait_hi(1, {nm, "_w"});
                @(posedge ACLK);
                @(negedge ACLK);
            end
            bus.S_AXI_WVALID = 1'b0;
            bus.S_AXI_WLAST  = 1'b0;
            for (int k = 0; k < v.hold; k++) begin
                check({nm, "_bhold"},
                      64'({bus.S_AXI_BVALID, bus.S_AXI_AWREADY}), 64'b10);
                @(negedge ACLK);
            end
            bus.S_AXI_BREADY = 1'b1;
            wait_hi(2, {nm, "_b"});
            check({nm, "_bresp_bid"},
                  64'({bus.S_AXI_BRESP, bus.S_AXI_BID}), 64'({v.bresp, id}));
            @(posedge ACLK);
            @(negedge ACLK);
            bus.S_AXI_BREADY = 1'b0;
            check({nm, "_after_b"},
                  64'({bus.S_AXI_BVALID, bus.S_AXI_AWREADY}), 64'b01);
        end else begin
            bus.S_AXI_ARADDR  = v.addr;
            bus.S_AXI_ARLEN   = v.len;
            bus.S_AXI_ARBURST = v.burst;
            bus.S_AXI_ARSIZE  = v.size;
            bus.S_AXI_ARID    = id;
            bus.S_AXI_ARVALID = 1'b1;
            wait_hi(3, {nm, "_ar"});
            @(posedge ACLK);
            @(negedge ACLK);
            bus.S_AXI_ARVALID = 1'b0;
            bus.S_AXI_RREADY  = 1'b1;
            for (int i = 0; i <= int'(v.len); i++) begin
                q  = (i < 4) ? v.d[i] : 32'd0;
                rs = (i < 4 && v.emask[i]) ? RESP_SLVERR : RESP_OKAY;
                if (i == 1 && v.hold > 0) begin
                    bus.S_AXI_RREADY = 1'b0;
                    for (int k = 0; k < v.hold; k++) begin
                        check($sformatf("%s_stall%0d", nm, k),
                              64'({bus.S_AXI_RVALID, bus.S_AXI_RDATA,
                                   bus.S_AXI_RLAST}),
                              64'({1'b1, q, 1'b0}));
                        @(negedge ACLK);
                    end
                    bus.S_AXI_RREADY = 1'b1;
                end
                wait_hi(4, {nm, "_r"});
                check($sformatf("%s_r%0d", nm, i),
                      64'({bus.S_AXI_RDATA, bus.S_AXI_RRESP,
                           bus.S_AXI_RLAST, bus.S_AXI_RID}),
                      64'({q, rs, (i == int'(v.len)), id}));
                @(posedge ACLK);
                @(negedge ACLK);
            end
            bus.S_AXI_RREADY = 1'b0;
            check({nm, "_after_r"},
                  64'({bus.S_AXI_RVALID, bus.S_AXI_ARREADY}), 64'b01);
        end
    endtask

    localparam logic [1:0] FX = BURST_FIXED;
    localparam logic [1:0] IN = BURST_INCR;
    localparam logic [1:0] WR = BURST_WRAP;
    localparam logic [2:0] SW = SIZE_WORD;
    localparam logic [1:0] OK = RESP_OKAY;
    localparam logic [1:0] SE = RESP_SLVERR;

    initial begin
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWSIZE = '0;
        bus.S_AXI_AWBURST = '0; bus.S_AXI_AWID = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_AWPROT = '0; bus.S_AXI_AWCACHE = '0; bus.S_AXI_AWLOCK = 1'b0;
        bus.S_AXI_AWQOS = '0; bus.S_AXI_AWREGION = '0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0;
        bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARSIZE = '0;
        bus.S_AXI_ARBURST = '0; bus.S_AXI_ARID = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_ARPROT = '0; bus.S_AXI_ARCACHE = '0; bus.S_AXI_ARLOCK = 1'b0;
        bus.S_AXI_ARQOS = '0; bus.S_AXI_ARREGION = '0; bus.S_AXI_RREADY = 1'b0;

        repeat (2) @(negedge ACLK);
        check("rst_outs", outs(), 64'd0);
        ARESET = 1'b0;
        check("rel_ready_low", 64'({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}), 64'b00);
        @(negedge ACLK);
        check("rel_ready_high", 64'({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}), 64'b11);

        vt.push_back(mk(1, 32'h04, 8'd3, IN, SW, 32'h10000000, 32'h10000001,
                        32'h10000002, 32'h10000003, 4'hF, 0, 0, OK, 4'h0));
        vt.push_back(mk(0, 32'h04, 8'd3, IN, SW, 32'h10000000, 32'h10000001,
                        32'h10000002, 32'h10000003, 4'hF, 0, 3, OK, 4'h0));
        vt.push_back(mk(1, 32'h08, 8'd2, FX, SW, 32'hA, 32'hB, 32'hC, 32'h0,
                        4'hF, 0, 5, OK, 4'h0));
        vt.push_back(mk(0, 32'h08, 8'd2, FX, SW, 32'hC, 32'hC, 32'hC, 32'h0,
                        4'hF, 0, 0, OK, 4'h0));
        vt.push_back(mk(0, 32'h04, 8'd3, IN, SW, 32'h10000000, 32'hC,
                        32'h10000002, 32'h10000003, 4'hF, 0, 0, OK, 4'h0));
        vt.push_back(mk(1, 32'h20, 8'd0, IN, SW, 32'h12345678, 32'h0, 32'h0,
                        32'h0, 4'hF, 0, 0, OK, 4'h0));
        vt.push_back(mk(1, 32'h20, 8'd0, IN, SW, 32'hFFFFFFFF, 32'h0, 32'h0,
                        32'h0, 4'b0101, 0, 0, OK, 4'h0));
        vt.push_back(mk(0, 32'h22, 8'd0, IN, SW, 32'h12FF56FF, 32'h0, 32'h0,
                        32'h0, 4'hF, 0, 0, OK, 4'h0));
        vt.push_back(mk(1, 32'hF8, 8'd3, IN, SW, 32'h1, 32'h2, 32'h3, 32'h4,
                        4'hF, 0, 0, SE, 4'h0));
        vt.push_back(mk(0, 32'hF8, 8'd3, IN, SW, 32'h1, 32'h2, 32'h0, 32'h0,
                        4'hF, 0, 0, OK, 4'b1100));
        vt.push_back(mk(1, 32'h30, 8'd0, WR, SW, 32'h55, 32'h0, 32'h0, 32'h0,
                        4'hF, 0, 0, SE, 4'h0));
        vt.push_back(mk(0, 32'h30, 8'd0, IN, SW, 32'h0, 32'h0, 32'h0, 32'h0,
                        4'hF, 0, 0, OK, 4'h0));
        vt.push_back(mk(1, 32'h34, 8'd1, IN, SW, 32'h7, 32'h8, 32'h0, 32'h0,
                        4'hF, 1, 0, SE, 4'h0));
        vt.push_back(mk(0, 32'h34, 8'd1, IN, SW, 32'h7, 32'h8, 32'h0, 32'h0,
                        4'hF, 0, 0, OK, 4'h0));
        vt.push_back(mk(0, 32'h34, 8'd0, IN, 3'b011, 32'h0, 32'h0, 32'h0,
                        32'h0, 4'hF, 0, 0, OK, 4'b0001));
        vt.push_back(mk(0, 32'h30, 8'd0, WR, SW, 32'h0, 32'h0, 32'h0, 32'h0,
                        4'hF, 0, 0, OK, 4'b0001));
        vt.push_back(mk(1, 32'h100, 8'd0, IN, SW, 32'h99, 32'h0, 32'h0, 32'h0,
                        4'hF, 0, 0, SE, 4'h0));
        vt.push_back(mk(0, 32'hFC, 8'd1, IN, SW, 32'h2, 32'h0, 32'h0, 32'h0,
                        4'hF, 0, 0, OK, 4'b0010));
        vt.push_back(mk(1, 32'h3C, 8'd255, FX, SW, 32'h0, 32'h1, 32'h2, 32'h3,
                        4'hF, 0, 0, OK, 4'h0));
        vt.push_back(mk(0, 32'h3C, 8'd0, IN, SW, 32'hFF, 32'h0, 32'h0, 32'h0,
                        4'hF, 0, 0, OK, 4'h0));

        for (int n = 0; n < vt.size(); n++) begin
            run(vt[n], 4'(n), $sformatf("v%0d", n));
        end

        // W data offered before any AW must not be taken.
        bus.S_AXI_WDATA  = 32'hDEAD0000;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WLAST  = 1'b0;
        bus.S_AXI_WVALID = 1'b1;
        repeat (2) begin
            @(negedge ACLK);
            check("w_before_aw", 64'(bus.S_AXI_WREADY), 64'd0);
        end
        bus.S_AXI_AWADDR  = 32'h40;
        bus.S_AXI_AWLEN   = 8'd3;
        bus.S_AXI_AWBURST = IN;
        bus.S_AXI_AWSIZE  = SW;
        bus.S_AXI_AWID    = 4'h9;
        bus.S_AXI_AWVALID = 1'b1;
        wait_hi(0, "mid_aw");
        @(posedge ACLK);
        @(negedge ACLK);
        bus.S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.S_AXI_WDATA = 32'hAA0 + 32'(i);
            wait_hi(1, "mid_w");
            @(posedge ACLK);
            @(negedge ACLK);
        end
        ARESET = 1'b1;
        #1;
        check("mid_rst_outs", outs(), 64'd0);
        bus.S_AXI_WVALID = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        check("mid_rel_aw_low", 64'(bus.S_AXI_AWREADY), 64'd0);
        @(negedge ACLK);
        check("mid_rel_aw_high", 64'(bus.S_AXI_AWREADY), 64'd1);

        run(mk(1, 32'h40, 8'd1, IN, SW, 32'h77, 32'h78, 32'h0, 32'h0,
               4'hF, 0, 0, OK, 4'h0), 4'h5, "post_w");
        run(mk(0, 32'h40, 8'd1, IN, SW, 32'h77, 32'h78, 32'h0, 32'h0,
               4'hF, 0, 0, OK, 4'h0), 4'h6, "post_r");
        run(mk(0, 32'h04, 8'd0, IN, SW, 32'h0, 32'h0, 32'h0, 32'h0,
               4'hF, 0, 0, OK, 4'h0), 4'h7, "clr_r4");
        run(mk(0, 32'h3C, 8'd0, IN, SW, 32'h0, 32'h0, 32'h0, 32'h0,
               4'hF, 0, 0, OK, 4'h0), 4'h8, "clr_r3c");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
